// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller.
// 256 lines x 4 bytes. Valid bits and tags live here; line data lives in an
// external byte-wide data RAM that returns read data on the falling edge of
// the cycle it is enabled.
module cache_ctrl #(
  parameter int TAG_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [7:0]  ram_index,
  output logic [1:0]  ram_byte,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FILL   = 3'd2,
    ST_WLINE  = 3'd3,
    ST_WMEM   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  // Request latched at acceptance; everything after IDLE works from these.
  logic [15:0]      r_addr;
  logic             r_rw;
  logic [7:0]       r_wdata;

  // Directory: valid bits are reset, tags are not (a cleared valid bit is
  // enough to make every line miss).
  logic [255:0]     r_valid;
  logic [TAG_W-1:0] r_tag [256];

  // Fill line buffer, byte counter for the line write, and the read result.
  logic [31:0]      r_line;
  logic [1:0]       r_cnt;
  logic [7:0]       r_rdata;

  logic [TAG_W-1:0] w_tag;
  logic [7:0]       w_index;
  logic [1:0]       w_byte;
  logic             w_hit;
  logic             w_last_byte;

  assign w_tag       = TAG_W'(r_addr[15:10]);
  assign w_index     = r_addr[9:2];
  assign w_byte      = r_addr[1:0];
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_last_byte = (r_cnt == 2'd3);
  assign cpu_rdata   = r_rdata;

  // State register; reset aborts whatever operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; all outputs derive from registered state.
  always_comb begin
    w_next    = r_state;
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    ram_en    = 1'b0;
    ram_rw    = 1'b0;
    ram_index = w_index;
    ram_byte  = w_byte;
    ram_wdata = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) begin
          w_next = ST_LOOKUP;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (r_rw) begin
          if (w_hit) begin
            // Read hit: RAM answers on this cycle's falling edge.
            ram_en = 1'b1;
            ram_rw = 1'b1;
            w_next = ST_RESP;
          end else begin
            w_next = ST_FILL;
          end
        end else begin
          if (w_hit) begin
            // Write hit updates only the addressed byte of the line.
            ram_en = 1'b1;
            ram_rw = 1'b0;
          end else begin
            // No write-allocate: a write miss never touches the RAM.
            ram_en = 1'b0;
          end
          w_next = ST_WMEM;
        end
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = {r_addr[15:2], 2'b00};
        if (mem_ack) begin
          w_next = ST_WLINE;
        end else begin
          w_next = ST_FILL;
        end
      end
      ST_WLINE: begin
        ram_en    = 1'b1;
        ram_rw    = 1'b0;
        ram_byte  = r_cnt;
        ram_wdata = r_line[{r_cnt, 3'b000} +: 8];
        if (w_last_byte) begin
          w_next = ST_RESP;
        end else begin
          w_next = ST_WLINE;
        end
      end
      ST_WMEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (mem_ack) begin
          w_next = ST_RESP;
        end else begin
          w_next = ST_WMEM;
        end
      end
      ST_RESP: begin
        cpu_ready = 1'b1;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: request latch, line buffer, byte counter, valid bits, read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 16'h0000;
      r_rw    <= 1'b0;
      r_wdata <= 8'h00;
      r_valid <= 256'd0;
      r_line  <= 32'h0000_0000;
      r_cnt   <= 2'd0;
      r_rdata <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_rw    <= cpu_rw;
            r_wdata <= cpu_wdata;
          end
        end
        ST_LOOKUP: begin
          r_cnt <= 2'd0;
          if (r_rw && w_hit) begin
            r_rdata <= ram_rdata;
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            r_line <= mem_rdata;
          end
        end
        ST_WLINE: begin
          r_cnt <= r_cnt + 2'd1;
          if (w_last_byte) begin
            // Line becomes valid only once all four bytes are in the RAM.
            r_valid[w_index] <= 1'b1;
            r_rdata          <= r_line[{w_byte, 3'b000} +: 8];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag store: written together with the valid bit at the end of a line fill.
  always_ff @(posedge clk) begin
    if ((r_state == ST_WLINE) && w_last_byte) begin
      r_tag[w_index] <= w_tag;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: randomized bench for cache_ctrl with a transaction-level
// reference model (main memory array + valid/tag directory) and an external
// data-RAM model answering on the falling edge.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [7:0]  ram_rdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready, mem_req, mem_we, ram_en, ram_rw;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, ram_index, ram_wdata;
  logic [1:0]  ram_byte;

  cache_ctrl #(.TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_index(ram_index), .ram_byte(ram_byte),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [7:0]  rdata;
    logic        mreq;
    logic        mwe;
    logic [15:0] maddr;
    logic [7:0]  mwdata;
    logic        ren;
    logic        rrw;
    logic [7:0]  ridx;
    logic [1:0]  rbyte;
    logic [7:0]  rwdata;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ram_wr = 0;

  // Reference model: memory contents, cache directory, last read result.
  logic [7:0] mem_model [65536];
  bit         m_valid [256];
  logic [5:0] m_tag [256];
  logic [7:0] m_rdata = 8'h00;
  exp_t       exp_q[$];
  exp_t       cmp_e;

  // External data RAM contents, written only by the DUT.
  logic [7:0] ram_arr [256][4];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.ready = 1'b0; e.rdata = m_rdata; e.mreq = 1'b0; e.mwe = 1'b0;
    e.maddr = 16'h0; e.mwdata = 8'h0; e.ren = 1'b0; e.rrw = 1'b0;
    e.ridx = 8'h0; e.rbyte = 2'd0; e.rwdata = 8'h0;
    return e;
  endfunction

  // Data RAM: reads answer on the falling edge, writes land in the array.
  always @(negedge clk) begin
    if (rst_n && ram_en) begin
      if (ram_rw) begin
        ram_rdata = ram_arr[ram_index][ram_byte];
      end else begin
        ram_arr[ram_index][ram_byte] = ram_wdata;
        n_ram_wr++;
      end
    end
  end

  // Compare process: one expected entry per busy cycle, idle rules otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
      chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
      chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
      chk("rst_ram_en",    {31'd0, ram_en},    32'd0);
    end else if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, cmp_e.ready});
      chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cmp_e.rdata});
      chk("mem_req",   {31'd0, mem_req},   {31'd0, cmp_e.mreq});
      chk("mem_we",    {31'd0, mem_we},    {31'd0, cmp_e.mwe});
      if (cmp_e.mreq) begin
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, cmp_e.maddr});
        if (cmp_e.mwe) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, cmp_e.mwdata});
      end
      chk("ram_en", {31'd0, ram_en}, {31'd0, cmp_e.ren});
      if (cmp_e.ren) begin
        chk("ram_rw",    {31'd0, ram_rw},    {31'd0, cmp_e.rrw});
        chk("ram_index", {24'd0, ram_index}, {24'd0, cmp_e.ridx});
        chk("ram_byte",  {30'd0, ram_byte},  {30'd0, cmp_e.rbyte});
        if (!cmp_e.rrw) chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, cmp_e.rwdata});
      end
    end else begin
      chk("idle_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      chk("idle_cpu_rdata", {24'd0, cpu_rdata}, {24'd0, m_rdata});
      chk("idle_mem_req",   {31'd0, mem_req},   32'd0);
      chk("idle_mem_we",    {31'd0, mem_we},    32'd0);
      chk("idle_ram_en",    {31'd0, ram_en},    32'd0);
    end
  end

  // One CPU transaction: queue the expected per-cycle outputs, update the
  // model, then drive the request and the memory acknowledge (mem_ack in the
  // a-th memory cycle) with noise on inputs that must be ignored.
  task automatic txn(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                     input int a, input int abort_at,
                     output int lat, output logic [7:0] rd,
                     output logic saw_mreq, output logic [15:0] maddr);
    logic [7:0]  idx;
    logic [15:0] base;
    logic        hit;
    logic [31:0] line;
    int          n;
    exp_t        e;
    idx  = addr[9:2];
    base = {addr[15:2], 2'b00};
    hit  = m_valid[idx] && (m_tag[idx] == addr[15:10]);
    line = {mem_model[base + 16'd3], mem_model[base + 16'd2],
            mem_model[base + 16'd1], mem_model[base]};
    @(negedge clk); #1;
    if (rw && hit) n = 1;
    else if (rw)   n = 5 + a;
    else           n = 1 + a;
    for (int k = 0; k <= n; k++) begin
      e = blank();
      if (k == n) begin
        e.ready = 1'b1;
        if (rw) e.rdata = mem_model[addr];
      end else if (rw && hit) begin
        e.ren = 1'b1; e.rrw = 1'b1; e.ridx = idx; e.rbyte = addr[1:0];
      end else if (rw) begin
        if (k >= 1 && k <= a) begin
          e.mreq = 1'b1; e.maddr = base;
        end else if (k > a) begin
          e.ren = 1'b1; e.ridx = idx; e.rbyte = 2'(k - a - 1);
          e.rwdata = mem_model[base + 16'(k - a - 1)];
        end
      end else begin
        if (k == 0) begin
          if (hit) begin
            e.ren = 1'b1; e.ridx = idx; e.rbyte = addr[1:0]; e.rwdata = wd;
          end
        end else begin
          e.mreq = 1'b1; e.mwe = 1'b1; e.maddr = addr; e.mwdata = wd;
        end
      end
      exp_q.push_back(e);
    end
    if (rw) begin
      m_rdata = mem_model[addr];
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = addr[15:10];
      end
    end else begin
      mem_model[addr] = wd;
    end

    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    lat = -1; rd = 8'h00; saw_mreq = 1'b0; maddr = 16'h0000;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk); #1;
      if (k == abort_at) begin
        rst_n = 1'b0; cpu_req = 1'b0; mem_ack = 1'b0;
        exp_q.delete();
        m_rdata = 8'h00;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        #1;
        chk("abort_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("abort_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("abort_mem_req",   {31'd0, mem_req},   32'd0);
        chk("abort_mem_we",    {31'd0, mem_we},    32'd0);
        chk("abort_ram_en",    {31'd0, ram_en},    32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (cpu_ready && lat < 0) begin
        lat = k; rd = cpu_rdata;
      end
      if (mem_req) begin
        saw_mreq = 1'b1; maddr = mem_addr;
      end
      cpu_req = 1'($urandom); cpu_rw = 1'($urandom);
      cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      mem_rdata = $urandom;
      if (!(rw && hit) && k >= 1 && k <= a) begin
        mem_ack = (k == a);
        if (k == a && rw) mem_rdata = line;
      end else begin
        mem_ack = 1'($urandom);
      end
      if (k == n) begin
        cpu_req = 1'b0; mem_ack = 1'b0;
      end
    end
  endtask

  int          lat;
  logic [7:0]  rd;
  logic        smr;
  logic [15:0] ma;
  int          wr0;

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 6'd0;
      for (int b = 0; b < 4; b++) ram_arr[i][b] = 8'h00;
    end
    mem_model[16'h0404] = 8'hAA; mem_model[16'h0405] = 8'hBB;
    mem_model[16'h0406] = 8'hCC; mem_model[16'h0407] = 8'hDD;

    // Asynchronous reset, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("por_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("por_mem_req",   {31'd0, mem_req},   32'd0);
    chk("por_ram_en",    {31'd0, ram_en},    32'd0);
    chk("por_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Cold read miss with ack after 2 cycles.
    wr0 = n_ram_wr;
    txn(1'b1, 16'h0405, 8'h00, 2, -1, lat, rd, smr, ma);
    chk("cold_lat",   32'(lat), 32'd7);
    chk("cold_rdata", {24'd0, rd}, 32'h0000_00BB);
    chk("cold_maddr", {16'd0, ma}, 32'h0000_0404);
    chk("cold_ramwr", 32'(n_ram_wr - wr0), 32'd4);
    chk("cold_line",  {ram_arr[1][3], ram_arr[1][2], ram_arr[1][1], ram_arr[1][0]}, 32'hDDCC_BBAA);

    // Same line hits.
    txn(1'b1, 16'h0407, 8'h00, 1, -1, lat, rd, smr, ma);
    chk("hit_lat",   32'(lat), 32'd1);
    chk("hit_rdata", {24'd0, rd}, 32'h0000_00DD);
    chk("hit_nomem", {31'd0, smr}, 32'd0);

    // Write hit, then reads of the written and an untouched byte.
    txn(1'b0, 16'h0406, 8'h55, 1, -1, lat, rd, smr, ma);
    chk("wr_lat",   32'(lat), 32'd2);
    chk("wr_maddr", {16'd0, ma}, 32'h0000_0406);
    chk("wr_ram",   {24'd0, ram_arr[1][2]}, 32'h0000_0055);
    txn(1'b1, 16'h0406, 8'h00, 1, -1, lat, rd, smr, ma);
    chk("wr_rd_back", {24'd0, rd}, 32'h0000_0055);
    chk("wr_rd_lat",  32'(lat), 32'd1);
    txn(1'b1, 16'h0404, 8'h00, 1, -1, lat, rd, smr, ma);
    chk("wr_other_byte", {24'd0, rd}, 32'h0000_00AA);

    // Write miss: no RAM access; following read misses and fills.
    wr0 = n_ram_wr;
    txn(1'b0, 16'h8004, 8'h11, 3, -1, lat, rd, smr, ma);
    chk("wmiss_lat",   32'(lat), 32'd4);
    chk("wmiss_noram", 32'(n_ram_wr - wr0), 32'd0);
    txn(1'b1, 16'h8004, 8'h00, 2, -1, lat, rd, smr, ma);
    chk("wmiss_rd_lat",   32'(lat), 32'd7);
    chk("wmiss_rd_rdata", {24'd0, rd}, 32'h0000_0011);

    // Conflict on index 1: tag replacement, then the old tag misses.
    txn(1'b1, 16'h0C05, 8'h00, 1, -1, lat, rd, smr, ma);
    chk("conf_lat", 32'(lat), 32'd6);
    txn(1'b1, 16'h0405, 8'h00, 1, -1, lat, rd, smr, ma);
    chk("conf_back_lat",   32'(lat), 32'd6);
    chk("conf_back_rdata", {24'd0, rd}, 32'h0000_00BB);

    // Reset during line write byte 2 (cycle a+3), then the re-read misses.
    txn(1'b1, 16'h0C05, 8'h00, 2, 5, lat, rd, smr, ma);
    chk("abort_no_ready", 32'(lat), 32'hFFFF_FFFF);
    txn(1'b1, 16'h0C05, 8'h00, 1, -1, lat, rd, smr, ma);
    chk("abort_reread_lat", 32'(lat), 32'd6);

    // Randomized traffic over a small address set to mix hits and misses.
    for (int t = 0; t < 300; t++) begin
      logic [15:0] addr;
      addr = {6'($urandom_range(0, 3)), 8'($urandom_range(16, 19)), 2'($urandom)};
      txn(1'($urandom_range(0, 2) != 0), addr, 8'($urandom), $urandom_range(1, 4),
          ((t % 50) == 25) ? int'($urandom_range(0, 6)) : -1, lat, rd, smr, ma);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
